vga_scandoubler: RTL and testbench
==================================

Name: vga_scandoubler

Overview:
- Sits directly downstream of the frame synthesizer and consumes its 240p pixel stream: RGB332, hs, vs and display-enable.
- Produces a 480-line stream for a VGA monitor by buffering each input line and replaying it twice at double rate.
- Runs entirely in the 2x pixel clock domain; input pixels are qualified by a clock enable.

Parameters:
H_RES, 320, active pixels per line (line buffer depth)
H_TOTAL, 422, total pixel periods per input line (= output clocks per output line)
H_SYNC_STA, 23, output h count at which hsync becomes active
H_SYNC_LEN, 32, hsync length in output clocks
H_ACT_STA, 101, output h count of first active pixel
H_POL, 0, hsync polarity (0: active low, 1: active high)
V_POL, 0, input/output vsync polarity (pass-through only)

Ports:
vga_clk  in  1  2x pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high
pix_ce  in  1  input pixel enable, high every 2nd vga_clk cycle
in_r  in  3  input red
in_g  in  3  input green
in_b  in  2  input blue
in_hs  in  1  input hsync, polarity per H_POL
in_vs  in  1  input vsync
in_de  in  1  input display enable
out_r  out  3  output red
out_g  out  3  output green
out_b  out  2  output blue
out_hs  out  1  output hsync, polarity per H_POL
out_vs  out  1  output vsync
out_de  out  1  output display enable
out_rep  out  1  0 = first replay of a line, 1 = second replay

Behaviour:
- Inputs are sampled only on cycles with pix_ce=1.
- Storage: two line buffers, each H_RES x 8 bits. wsel selects the write buffer; the read buffer is always ~wsel.
- Write path, on pix_ce & in_de:
  - if waddr < H_RES: buf[wsel][waddr] <= {r,g,b}, waddr++;
  - else the pixel is dropped (saturate; no wrap).
- Line end = in_de sampled 1 then 0 on consecutive pix_ce cycles:
  - wsel toggles, rd_count <= waddr, waddr <= 0, seen_de <= 1.
- Line start = in_hs transitions inactive->active between consecutive pix_ce samples:
  - out_h <= 0 and out_rep <= 0;
  - if seen_de == 0, rd_count <= 0 (blank line, used during vblank);
  - seen_de is then cleared.
- out_h counter otherwise counts 0..H_TOTAL-1 and wraps to 0. out_rep toggles on each wrap.
- Read path:
  - read address = out_h - H_ACT_STA;
  - pixel is active when out_h is in [H_ACT_STA, H_ACT_STA+H_RES) and the address < rd_count;
  - outside that, RGB = 0.
- Pipeline: the buffer read is registered (1 cycle), then the output registers (1 cycle).
  - out_r/g/b, out_de and out_hs all reflect the out_h value from 2 cycles earlier and stay aligned.
- out_hs is active when out_h is in [H_SYNC_STA, H_SYNC_STA+H_SYNC_LEN).
- out_de is high exactly when the pixel is active. RGB is forced to 0 whenever out_de=0.
- out_vs = in_vs delayed by 2 vga_clk cycles. There is no vertical resampling; the input line count already doubles.
- Simultaneous line end and line start on the same pix_ce: process line end first (swap, rd_count <= waddr), then line start resets out_h; seen_de counts as 1 for that edge.
- Reset (valid at any time, including mid-line):
  - wsel=0, waddr=0, rd_count=0, seen_de=0, out_h=0, out_rep=0;
  - out_r/g/b=0, out_de=0;
  - out_hs and out_vs at inactive level (~H_POL, ~V_POL).
  - Buffer contents are not cleared; rd_count=0 guarantees black output until a full line has been captured.

Test Plan:
- Reset then idle (pix_ce toggling, in_de=0, no hs edge) -> out_de=0 and RGB=0 throughout; out_hs low for 32 clocks every 422 clocks starting at out_h=23+2 latency.
- One input line of 320 pixels with pixel value = x[7:0], then hs edge -> the following 844 clocks carry two output lines with out_rep 0 then 1. Each line shows values 0..319 mod 256 on out_de cycles starting 103 clocks after the resync.
- Input line of 200 pixels (short de) -> output pixels 0..199 match; pixels 200..319 are RGB=0 with out_de=0.
- Input line of 400 pixels -> first 320 stored, rd_count=320, no corruption of the other buffer.
- Vblank line (hs edge with no de since previous edge) after a valid line -> next output line pair fully black.
- Assert reset for 1 cycle mid-replay (out_h=150) -> next cycle all outputs at reset values, and black until a new full input line completes.

Source files
------------

// File: rtl/vga_scandoubler.sv
// rtl/vga_scandoubler.sv - 240p to 480-line scan doubler: two line buffers, each input line replayed twice at 2x rate.
module vga_scandoubler #(
    parameter int H_RES      = 320,
    parameter int H_TOTAL    = 422,
    parameter int H_SYNC_STA = 23,
    parameter int H_SYNC_LEN = 32,
    parameter int H_ACT_STA  = 101,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic [2:0] in_r,
    input  logic [2:0] in_g,
    input  logic [1:0] in_b,
    input  logic       in_hs,
    input  logic       in_vs,
    input  logic       in_de,
    output logic [2:0] out_r,
    output logic [2:0] out_g,
    output logic [1:0] out_b,
    output logic       out_hs,
    output logic       out_vs,
    output logic       out_de,
    output logic       out_rep
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int AW = $clog2(H_RES + 1);
    localparam int IW = $clog2(H_RES);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] ACT_STA  = HW'(H_ACT_STA);
    localparam logic [HW-1:0] ACT_END  = HW'(H_ACT_STA + H_RES);
    localparam logic [HW-1:0] SYNC_STA = HW'(H_SYNC_STA);
    localparam logic [HW-1:0] SYNC_END = HW'(H_SYNC_STA + H_SYNC_LEN);
    localparam logic [AW-1:0] RES      = AW'(H_RES);

    logic [7:0]    line_buf_q [2][H_RES];

    logic          wsel_q,     wsel_d;
    logic [AW-1:0] waddr_q,    waddr_d;
    logic [AW-1:0] rd_count_q, rd_count_d;
    logic          seen_de_q,  seen_de_d;
    logic [HW-1:0] out_h_q,    out_h_d;
    logic          out_rep_q,  out_rep_d;
    logic          prev_de_q,  prev_de_d;
    logic          prev_hs_q,  prev_hs_d;

    logic [7:0]    rd_data_q;
    logic          act_q;
    logic          hs_win_q;
    logic          vs_d1_q;
    logic [7:0]    out_rgb_q;
    logic          out_de_q;
    logic          out_hs_q;
    logic          out_vs_q;

    logic          hs_act;
    logic          de_fall;
    logic          hs_rise;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [HW-1:0] rel;
    logic          in_win;
    logic          pix_act;
    logic          hs_win;
    logic [IW-1:0] rd_idx;

    assign hs_act  = (in_hs == H_POL);
    assign de_fall = pix_ce & prev_de_q & ~in_de;
    assign hs_rise = pix_ce & hs_act & ~prev_hs_q;
    assign wr_en   = pix_ce & in_de & (waddr_q < RES);
    assign wr_idx  = IW'(waddr_q);

    // Read side looks at the buffer not being written; address is relative to the active window.
    assign rel     = out_h_q - ACT_STA;
    assign in_win  = (out_h_q >= ACT_STA) && (out_h_q < ACT_END);
    assign pix_act = in_win && (AW'(rel) < rd_count_q);
    assign rd_idx  = in_win ? IW'(rel) : '0;
    assign hs_win  = (out_h_q >= SYNC_STA) && (out_h_q < SYNC_END);

    always_comb begin
        wsel_d     = wsel_q;
        waddr_d    = waddr_q;
        rd_count_d = rd_count_q;
        seen_de_d  = seen_de_q;
        out_h_d    = (out_h_q == H_LAST) ? '0 : out_h_q + 1'b1;
        out_rep_d  = (out_h_q == H_LAST) ? ~out_rep_q : out_rep_q;
        prev_de_d  = pix_ce ? in_de : prev_de_q;
        prev_hs_d  = pix_ce ? hs_act : prev_hs_q;

        if (wr_en) begin
            waddr_d = waddr_q + 1'b1;
        end

        if (de_fall) begin
            wsel_d     = ~wsel_q;
            rd_count_d = waddr_q;
            waddr_d    = '0;
            seen_de_d  = 1'b1;
        end

        // A line end on the same sample counts as a seen line, so its count survives.
        if (hs_rise) begin
            out_h_d   = '0;
            out_rep_d = 1'b0;
            if (!seen_de_q && !de_fall) begin
                rd_count_d = '0;
            end
            seen_de_d = 1'b0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (wr_en) begin
            line_buf_q[wsel_q][wr_idx] <= {in_r, in_g, in_b};
        end
        rd_data_q <= line_buf_q[~wsel_q][rd_idx];
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            wsel_q     <= 1'b0;
            waddr_q    <= '0;
            rd_count_q <= '0;
            seen_de_q  <= 1'b0;
            out_h_q    <= '0;
            out_rep_q  <= 1'b0;
            prev_de_q  <= 1'b0;
            prev_hs_q  <= 1'b0;
            act_q      <= 1'b0;
            hs_win_q   <= 1'b0;
            vs_d1_q    <= ~V_POL;
            out_rgb_q  <= '0;
            out_de_q   <= 1'b0;
            out_hs_q   <= ~H_POL;
            out_vs_q   <= ~V_POL;
        end else begin
            wsel_q     <= wsel_d;
            waddr_q    <= waddr_d;
            rd_count_q <= rd_count_d;
            seen_de_q  <= seen_de_d;
            out_h_q    <= out_h_d;
            out_rep_q  <= out_rep_d;
            prev_de_q  <= prev_de_d;
            prev_hs_q  <= prev_hs_d;
            act_q      <= pix_act;
            hs_win_q   <= hs_win;
            vs_d1_q    <= in_vs;
            out_rgb_q  <= act_q ? rd_data_q : '0;
            out_de_q   <= act_q;
            out_hs_q   <= hs_win_q ? H_POL : ~H_POL;
            out_vs_q   <= vs_d1_q;
        end
    end

    assign {out_r, out_g, out_b} = out_rgb_q;
    assign out_de  = out_de_q;
    assign out_hs  = out_hs_q;
    assign out_vs  = out_vs_q;
    assign out_rep = out_rep_q;

endmodule

// File: tb/tb_vga_scandoubler.sv
// tb/tb_vga_scandoubler.sv - randomized bench for vga_scandoubler against a line-level behavioural model.
module tb_vga_scandoubler;

    localparam int H_RES    = 320;
    localparam int H_TOTAL  = 422;
    localparam int SYNC_STA = 23;
    localparam int SYNC_LEN = 32;
    localparam int ACT_STA  = 101;
    localparam int WATCH    = 2 * H_TOTAL + 1;
    localparam int NO_SWAP  = 1 << 30;
    localparam logic [12:0] RST_OUT = 13'b00000000_0_1_1_0;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       pix_ce  = 1'b0;
    logic [2:0] in_r    = '0;
    logic [2:0] in_g    = '0;
    logic [1:0] in_b    = '0;
    logic       in_hs   = 1'b1;
    logic       in_vs   = 1'b1;
    logic       in_de   = 1'b0;
    logic [2:0] out_r;
    logic [2:0] out_g;
    logic [1:0] out_b;
    logic       out_hs;
    logic       out_vs;
    logic       out_de;
    logic       out_rep;

    vga_scandoubler dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .pix_ce  (pix_ce),
        .in_r    (in_r),
        .in_g    (in_g),
        .in_b    (in_b),
        .in_hs   (in_hs),
        .in_vs   (in_vs),
        .in_de   (in_de),
        .out_r   (out_r),
        .out_g   (out_g),
        .out_b   (out_b),
        .out_hs  (out_hs),
        .out_vs  (out_vs),
        .out_de  (out_de),
        .out_rep (out_rep)
    );

    always #5 vga_clk = ~vga_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         ce_at_edge;
    logic [7:0] disp_line [H_RES];
    logic [7:0] pend_line [H_RES];
    int         disp_count = 0;
    int         pend_count = 0;
    bit         seen = 0;
    int         swap_k = NO_SWAP;

    task automatic step();
        @(posedge vga_clk);
        ce_at_edge = pix_ce;
        #1;
        pix_ce = ~pix_ce;
    endtask

    task automatic ce_step();
        step();
        if (!ce_at_edge) step();
    endtask

    // Expected {rgb, de, hs, rep} k clocks after the line start (or reset) edge.
    function automatic logic [10:0] exp_out(input int k);
        int n, h, a, cnt;
        bit use_new, de, hs, rep;
        logic [7:0] px;
        n       = k - 2;
        h       = n % H_TOTAL;
        a       = h - ACT_STA;
        use_new = (n >= swap_k);
        cnt     = use_new ? pend_count : disp_count;
        de      = (h >= ACT_STA) && (h < ACT_STA + H_RES) && (a < cnt);
        px      = de ? (use_new ? pend_line[a] : disp_line[a]) : 8'h00;
        hs      = !((h >= SYNC_STA) && (h < SYNC_STA + SYNC_LEN));
        rep     = ((k / H_TOTAL) % 2) == 1;
        return {px, de, hs, rep};
    endfunction

    task automatic feed_line(input int n, input bit ramp, input bit end_line);
        logic [7:0] px;
        for (int i = 0; i < n; i++) begin
            px = ramp ? 8'(i) : 8'($urandom);
            in_de = 1'b1;
            {in_r, in_g, in_b} = px;
            if (i < H_RES) pend_line[i] = px;
            ce_step();
        end
        pend_count = (n < H_RES) ? n : H_RES;
        if (end_line) begin
            in_de = 1'b0;
            {in_r, in_g, in_b} = 8'h00;
            ce_step();
        end
    endtask

    task automatic model_line_end();
        disp_line  = pend_line;
        disp_count = pend_count;
        seen       = 1;
    endtask

    task automatic line_start();
        in_hs = 1'b0;
        ce_step();
        in_hs = 1'b1;
        if (!seen) disp_count = 0;
        seen   = 0;
        swap_k = NO_SWAP;
    endtask

    task automatic model_reset();
        disp_count = 0;
        seen       = 0;
        swap_k     = NO_SWAP;
    endtask

    task automatic test_reset_idle();
        logic [10:0] e, o;
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({out_r, out_g, out_b, out_de, out_hs, out_vs, out_rep} !== RST_OUT) begin
            n_fail++;
            $display("FAIL reset_state got %b expected %b",
                     {out_r, out_g, out_b, out_de, out_hs, out_vs, out_rep}, RST_OUT);
        end
        reset = 1'b0;
        model_reset();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL idle k=%0d got %h expected %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_ramp_line();
        logic [10:0] e, o;
        feed_line(H_RES, 1, 1);
        model_line_end();
        line_start();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL ramp k=%0d got %h expected %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_short_line();
        logic [10:0] e, o;
        feed_line(200, 0, 1);
        model_line_end();
        line_start();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL short k=%0d got %h expected %h", k, o, e);
                end
            end
        end
    endtask

    // A long line is written while the previous line is being replayed; the replay must stay intact.
    task automatic test_overflow();
        logic [10:0] e, o;
        logic [7:0]  px;
        int          b_idx;
        bit          ending;
        feed_line(H_RES, 0, 1);
        model_line_end();
        line_start();
        b_idx  = 0;
        ending = 0;
        px = 8'($urandom);
        pend_line[0] = px;
        in_de = 1'b1;
        {in_r, in_g, in_b} = px;
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (ce_at_edge && swap_k == NO_SWAP) begin
                if (ending) begin
                    swap_k = k;
                end else begin
                    b_idx++;
                    if (b_idx < 400) begin
                        px = 8'($urandom);
                        if (b_idx < H_RES) pend_line[b_idx] = px;
                        {in_r, in_g, in_b} = px;
                    end else begin
                        in_de = 1'b0;
                        {in_r, in_g, in_b} = 8'h00;
                        pend_count = H_RES;
                        ending = 1;
                    end
                end
            end
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL overflow_live k=%0d got %h expected %h", k, o, e);
                end
            end
        end
        model_line_end();
        line_start();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL overflow_replay k=%0d got %h expected %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_vblank();
        logic [10:0] e, o;
        line_start();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL vblank k=%0d got %h expected %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [10:0] e, o;
        feed_line(150, 0, 0);
        in_de = 1'b0;
        {in_r, in_g, in_b} = 8'h00;
        in_hs = 1'b0;
        ce_step();
        in_hs = 1'b1;
        model_line_end();
        seen   = 0;
        swap_k = NO_SWAP;
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL simultaneous k=%0d got %h expected %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_random_lines();
        logic [10:0] e, o;
        int len;
        for (int l = 0; l < 3; l++) begin
            len = $urandom_range(1, 400);
            feed_line(len, 0, 1);
            model_line_end();
            line_start();
            for (int k = 1; k <= WATCH; k++) begin
                step();
                if (k >= 2) begin
                    e = exp_out(k);
                    o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                    n_checks++;
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL random len=%0d k=%0d got %h expected %h", len, k, o, e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e, o;
        feed_line(H_RES, 0, 1);
        model_line_end();
        line_start();
        for (int k = 1; k <= 150; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL mid_pre k=%0d got %h expected %h", k, o, e);
                end
            end
        end
        reset = 1'b1;
        step();
        n_checks++;
        if ({out_r, out_g, out_b, out_de, out_hs, out_vs, out_rep} !== RST_OUT) begin
            n_fail++;
            $display("FAIL mid_reset got %b expected %b",
                     {out_r, out_g, out_b, out_de, out_hs, out_vs, out_rep}, RST_OUT);
        end
        reset = 1'b0;
        model_reset();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL mid_black k=%0d got %h expected %h", k, o, e);
                end
            end
        end
        line_start();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL mid_blank_line k=%0d got %h expected %h", k, o, e);
                end
            end
        end
        feed_line(H_RES, 0, 1);
        model_line_end();
        line_start();
        for (int k = 1; k <= WATCH; k++) begin
            step();
            if (k >= 2) begin
                e = exp_out(k);
                o = {out_r, out_g, out_b, out_de, out_hs, out_rep};
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL mid_recover k=%0d got %h expected %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_vsync();
        logic v [64];
        for (int j = 0; j < 64; j++) begin
            step();
            if (j >= 2) begin
                n_checks++;
                if (out_vs !== v[j-2]) begin
                    n_fail++;
                    $display("FAIL vsync j=%0d got %b expected %b", j, out_vs, v[j-2]);
                end
            end
            v[j] = 1'($urandom);
            in_vs = v[j];
        end
        in_vs = 1'b1;
    endtask

    initial begin
        test_reset_idle();
        test_ramp_line();
        test_short_line();
        test_overflow();
        test_vblank();
        test_simultaneous();
        test_random_lines();
        test_reset_mid();
        test_vsync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
